// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_ADD_MODE_EN to add a `mode` input selecting add (1) or subtract (0).
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for start; diff/borrow_out hold last result
// S_SHIFT | one difference bit per cycle, busy=1
// S_DONE  | result valid, done=1 for this single cycle
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic             mode_q, mode_d;
`endif

  logic x, y, c, d_bit, next_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Full-subtractor (or full-adder in add mode) cell on the operand LSBs.
  always_comb begin
    x      = a_q[0];
    y      = b_q[0];
    c      = carry_q;
    d_bit  = x ^ y ^ c;
    next_c = (~x & y) | (~(x ^ y) & c);
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (mode_q) begin
      next_c = (x & y) | (c & (x ^ y));
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          diff_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          mode_d  = mode;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        diff_d  = {d_bit, diff_q[WIDTH-1:1]};
        carry_d = next_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bout_d  = next_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed, randomized, timing and reset scenarios
// against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode       (mode),
`endif
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference: {borrow, diff} is the (WIDTH+1)-bit wrapped difference; add mode gives {carry, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                           input logic mm);
    if (mm) return {1'b0, ma} + {1'b0, mb};
    return {1'b0, ma} - {1'b0, mb};
  endfunction

  // Runs one operation and reports observations; comparisons are done by the callers.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic om,
                        output logic [WIDTH-1:0] od, output logic obo,
                        output int busy_cnt, output int done_at, output int done_cnt,
                        output int overlap);
    @(negedge clk);
    a = oa; b = ob; mode = om; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~oa; b = ~ob;
    busy_cnt = 0; done_at = -1; done_cnt = 0; overlap = 0;
    od = 'x; obo = 1'bx;
    for (int k = 0; k < WIDTH + 4; k++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          od  = diff;
          obo = borrow_out;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    #1;
    n_checks++;
    if ({diff, borrow_out, busy, done} !== '0)
      $display("FAIL reset_hold: got diff=%h bo=%b busy=%b done=%b, want all 0", diff, borrow_out, busy, done);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({diff, borrow_out, busy, done} !== '0)
      $display("FAIL reset_idle: got diff=%h bo=%b busy=%b done=%b, want all 0", diff, borrow_out, busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [5] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80};
    logic [WIDTH-1:0] tb [5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h7F};
    logic [WIDTH-1:0] td [5] = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h01};
    logic             tbo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] od; logic obo; int bc, da, dc, ov;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b0, od, obo, bc, da, dc, ov);
      n_checks++;
      if (od !== td[i] || obo !== tbo[i])
        $display("FAIL directed_%0d: got diff=%h bo=%b, want diff=%h bo=%b", i, od, obo, td[i], tbo[i]);
      else n_pass++;
      n_checks++;
      if (bc !== WIDTH || da !== WIDTH || dc !== 1 || ov !== 0)
        $display("FAIL timing_%0d: got busy_cycles=%0d done_at=%0d done_cycles=%0d overlap=%0d, want %0d %0d 1 0",
                 i, bc, da, dc, ov, WIDTH, WIDTH);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, od; logic obo; logic [WIDTH:0] exp; int bc, da, dc, ov;
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      exp = model(ra, rb, 1'b0);
      run_op(ra, rb, 1'b0, od, obo, bc, da, dc, ov);
      n_checks++;
      if (od !== exp[WIDTH-1:0] || obo !== exp[WIDTH] || da !== WIDTH || dc !== 1)
        $display("FAIL random_%0d: a=%h b=%h got diff=%h bo=%b done_at=%0d, want diff=%h bo=%b done_at=%0d",
                 i, ra, rb, od, obo, da, exp[WIDTH-1:0], exp[WIDTH], WIDTH);
      else n_pass++;
    end
  endtask

  task automatic test_ignored_start();
    int seen;
    @(negedge clk);
    a = 8'h10; b = 8'h01; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h00; b = 8'hFF;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(posedge clk); #1;
      if (k == WIDTH) begin
        n_checks++;
        if (done !== 1'b1 || diff !== 8'h0F || borrow_out !== 1'b0)
          $display("FAIL ignored_start_result: got done=%b diff=%h bo=%b, want done=1 diff=0f bo=0",
                   done, diff, borrow_out);
        else n_pass++;
      end
      if (k == WIDTH + 1) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
          $display("FAIL ignored_start_idle: got busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
      end
      if (k == WIDTH + 2) begin
        n_checks++;
        if (busy !== 1'b1)
          $display("FAIL back_to_back_accept: got busy=%b, want 1", busy);
        else n_pass++;
      end
    end
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 2 * WIDTH && seen == 0; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    n_checks++;
    if (seen !== 1 || diff !== 8'h01 || borrow_out !== 1'b1)
      $display("FAIL back_to_back_result: got seen=%0d diff=%h bo=%b, want seen=1 diff=01 bo=1",
               seen, diff, borrow_out);
    else n_pass++;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH-1:0] od; logic obo; int bc, da, dc, ov, dcount;
    run_op(8'h03, 8'h05, 1'b0, od, obo, bc, da, dc, ov);
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || borrow_out !== 1'b1)
      $display("FAIL midop_pre: got busy=%b bo=%b, want busy=1 bo=1", busy, borrow_out);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (diff !== '0 || borrow_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL midop_reset: got diff=%h bo=%b busy=%b done=%b, want all 0", diff, borrow_out, busy, done);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 2 * WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    n_checks++;
    if (dcount !== 0)
      $display("FAIL midop_no_done: got %0d cycles with busy/done, want 0", dcount);
    else n_pass++;
  endtask

`ifdef SERIAL_SUB_ADD_MODE_EN
  task automatic test_add_mode();
    logic [WIDTH-1:0] ra, rb, od; logic obo, rm; logic [WIDTH:0] exp; int bc, da, dc, ov;
    run_op(8'hFF, 8'h01, 1'b1, od, obo, bc, da, dc, ov);
    n_checks++;
    if (od !== 8'h00 || obo !== 1'b1 || da !== WIDTH)
      $display("FAIL add_ff_01: got diff=%h carry=%b done_at=%0d, want 00 1 %0d", od, obo, da, WIDTH);
    else n_pass++;
    run_op(8'h12, 8'h34, 1'b1, od, obo, bc, da, dc, ov);
    n_checks++;
    if (od !== 8'h46 || obo !== 1'b0 || da !== WIDTH)
      $display("FAIL add_12_34: got diff=%h carry=%b done_at=%0d, want 46 0 %0d", od, obo, da, WIDTH);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rm = 1'($urandom);
      exp = model(ra, rb, rm);
      run_op(ra, rb, rm, od, obo, bc, da, dc, ov);
      n_checks++;
      if (od !== exp[WIDTH-1:0] || obo !== exp[WIDTH] || bc !== WIDTH)
        $display("FAIL mixed_mode_%0d: mode=%b a=%h b=%h got %h/%b, want %h/%b",
                 i, rm, ra, rb, od, obo, exp[WIDTH-1:0], exp[WIDTH]);
      else n_pass++;
    end
    mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_reset_mid_op();
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
